// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control FSM with parameterised fetch wait.
// Optional macro MC_CTRL_TRAP_EN adds a sticky TRAP state for illegal opcodes.
module mc_controller #(
    parameter int FETCH_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       neg,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic       instr_done,
    output logic       trap
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, JAL, JALR, JALR2, BRANCH, LUI
`ifdef MC_CTRL_TRAP_EN
        , TRAP
`endif
    } state_t;

    state_t     state;
    state_t     state_n;
    state_t     illegal_st;
    logic [1:0] wcnt;
    logic       fetch_last;
    logic       is_load, is_store, is_r, is_i;
    logic       is_jal, is_jalr, is_br, is_lui;
    logic       taken;
    logic [2:0] alu_dec;

    assign fetch_last = (wcnt == 2'(FETCH_WAIT));

    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);
    assign is_r     = (op == OP_R);
    assign is_i     = (op == OP_I);
    assign is_jal   = (op == OP_JAL);
    assign is_jalr  = (op == OP_JALR);
    assign is_br    = (op == OP_BR);
    assign is_lui   = (op == OP_LUI);

`ifdef MC_CTRL_TRAP_EN
    assign illegal_st = TRAP;
`else
    assign illegal_st = FETCH;
`endif

    always_comb begin
        alu_dec = ALU_ADD;
        unique case (funct3)
            3'b000:  alu_dec = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b100:  alu_dec = ALU_XOR;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        unique case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = neg;
            3'b101:  taken = !neg;
            default: taken = 1'b0;
        endcase
    end

    // wait counter only advances while FETCH is stalled on memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            if (state == FETCH && !fetch_last)
                wcnt <= wcnt + 2'd1;
            else
                wcnt <= '0;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            FETCH:    state_n = fetch_last ? DECODE : FETCH;
            DECODE: begin
                unique case (1'b1)
                    is_load, is_store: state_n = MEMADR;
                    is_r:              state_n = EXECR;
                    is_i:              state_n = EXECI;
                    is_jal:            state_n = JAL;
                    is_jalr:           state_n = JALR;
                    is_br:             state_n = BRANCH;
                    is_lui:            state_n = LUI;
                    default:           state_n = illegal_st;
                endcase
            end
            MEMADR:   state_n = is_store ? MEMWRITE : MEMREAD;
            MEMREAD:  state_n = MEMWB;
            MEMWB:    state_n = FETCH;
            MEMWRITE: state_n = FETCH;
            EXECR:    state_n = ALUWB;
            EXECI:    state_n = ALUWB;
            ALUWB:    state_n = FETCH;
            JAL:      state_n = ALUWB;
            JALR:     state_n = JALR2;
            JALR2:    state_n = ALUWB;
            BRANCH:   state_n = FETCH;
            LUI:      state_n = FETCH;
`ifdef MC_CTRL_TRAP_EN
            TRAP:     state_n = TRAP;
`endif
            default:  state_n = FETCH;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = 3'b000;
        trap        = 1'b0;
        unique case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = fetch_last;
                pc_write   = fetch_last;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = is_jal ? 3'b011 : 3'b010;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = is_store ? 3'b001 : 3'b000;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_dec;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
            end
            ALUWB:    reg_write = 1'b1;
            JAL, JALR2: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = taken;
            end
            LUI: begin
                imm_src    = 3'b100;
                result_src = 2'b11;
                reg_write  = 1'b1;
            end
`ifdef MC_CTRL_TRAP_EN
            TRAP:     trap = 1'b1;
`endif
            default: ;
        endcase
        instr_done = (state != FETCH) && (state_n == FETCH);
        // reset holds every side-effecting strobe low
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            trap       = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: two instances (FETCH_WAIT 0 and 2)
// run directed and random instructions against a path-table reference model.
module tb_mc_controller;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // {pc,adr,mw,ir,rw,res[2],a[2],b[2],alu[3],imm[3],done,trap}
    localparam logic [18:0] RST_V = {5'b0, 2'b10, 2'b00, 2'b10, 3'b0, 3'b0, 2'b0};

    typedef enum int {
        S_FW, S_FL, S_DEC, S_MADR, S_MRD, S_MWB, S_MWR, S_ER, S_EI,
        S_AWB, S_JAL, S_JALR, S_JALR2, S_BR, S_LUI, S_TRAP
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst2, sel;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, neg;
    wire [18:0] v0, v2;
    wire [18:0] obs = sel ? v2 : v0;

    int n_checks = 0;
    int n_fail   = 0;
    step_t path[$];

    mc_controller #(.FETCH_WAIT(0)) dut0 (
        .clk(clk), .rst(rst0), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .neg(neg),
        .pc_write(v0[18]), .adr_src(v0[17]), .mem_write(v0[16]),
        .ir_write(v0[15]), .reg_write(v0[14]), .result_src(v0[13:12]),
        .alu_src_a(v0[11:10]), .alu_src_b(v0[9:8]),
        .alu_control(v0[7:5]), .imm_src(v0[4:2]),
        .instr_done(v0[1]), .trap(v0[0])
    );

    mc_controller #(.FETCH_WAIT(2)) dut2 (
        .clk(clk), .rst(rst2), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .neg(neg),
        .pc_write(v2[18]), .adr_src(v2[17]), .mem_write(v2[16]),
        .ir_write(v2[15]), .reg_write(v2[14]), .result_src(v2[13:12]),
        .alu_src_a(v2[11:10]), .alu_src_b(v2[9:8]),
        .alu_control(v2[7:5]), .imm_src(v2[4:2]),
        .instr_done(v2[1]), .trap(v2[0])
    );

    task automatic check(string tag, logic [18:0] got, logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(logic [6:0] o);
        return o inside {OP_LOAD, OP_STORE, OP_R, OP_I,
                         OP_JAL, OP_JALR, OP_BR, OP_LUI};
    endfunction

    function automatic void build_path(logic [6:0] o, int w);
        path.delete();
        repeat (w) path.push_back(S_FW);
        path.push_back(S_FL);
        path.push_back(S_DEC);
        case (o)
            OP_LOAD:  begin path.push_back(S_MADR); path.push_back(S_MRD);
                            path.push_back(S_MWB); end
            OP_STORE: begin path.push_back(S_MADR); path.push_back(S_MWR); end
            OP_R:     begin path.push_back(S_ER); path.push_back(S_AWB); end
            OP_I:     begin path.push_back(S_EI); path.push_back(S_AWB); end
            OP_JAL:   begin path.push_back(S_JAL); path.push_back(S_AWB); end
            OP_JALR:  begin path.push_back(S_JALR); path.push_back(S_JALR2);
                            path.push_back(S_AWB); end
            OP_BR:    path.push_back(S_BR);
            OP_LUI:   path.push_back(S_LUI);
            default: begin
`ifdef MC_CTRL_TRAP_EN
                repeat (3) path.push_back(S_TRAP);
`endif
            end
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(logic [2:0] f3, logic sub);
        case (f3)
            3'd0:    return sub ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd4:    return 3'b100;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [18:0] exp_out(step_t s, logic last,
            logic [6:0] o, logic [2:0] f3, logic f7, logic z, logic n);
        logic       pc = 0, adr = 0, mw = 0, ir = 0, rw = 0, tr = 0;
        logic [1:0] res = 0, a = 0, b = 0;
        logic [2:0] alu = 0, imm = 0;
        case (s)
            S_FW:    begin b = 2; res = 2; end
            S_FL:    begin b = 2; res = 2; ir = 1; pc = 1; end
            S_DEC:   begin a = 1; b = 1; imm = (o == OP_JAL) ? 3 : 2; end
            S_MADR:  begin a = 2; b = 1; imm = (o == OP_STORE) ? 1 : 0; end
            S_MRD:   adr = 1;
            S_MWB:   begin res = 1; rw = 1; end
            S_MWR:   begin adr = 1; mw = 1; end
            S_ER:    begin a = 2; alu = exp_alu(f3, (o == OP_R) && f7); end
            S_EI:    begin a = 2; b = 1; alu = exp_alu(f3, 1'b0); end
            S_AWB:   rw = 1;
            S_JAL:   begin a = 1; b = 2; pc = 1; end
            S_JALR:  begin a = 2; b = 1; end
            S_JALR2: begin a = 1; b = 2; pc = 1; end
            S_BR: begin
                a = 2; alu = 1;
                pc = (f3 == 0 && z) || (f3 == 1 && !z) ||
                     (f3 == 4 && n) || (f3 == 5 && !n);
            end
            S_LUI:   begin imm = 4; res = 3; rw = 1; end
            S_TRAP:  tr = 1;
            default: ;
        endcase
        return {pc, adr, mw, ir, rw, res, a, b, alu, imm,
                last && (s != S_TRAP), tr};
    endfunction

    // entered #1 after a posedge; leaves the selected DUT fresh in FETCH
    task automatic reset_cur(string tag);
        if (sel) rst2 = 1'b1; else rst0 = 1'b1;
        @(negedge clk);
        check(tag, obs, RST_V);
        @(posedge clk);
        #1;
        if (sel) rst2 = 1'b0; else rst0 = 1'b0;
    endtask

    // fz < 0: random flags each cycle; else bit0=zero, bit1=neg held
    task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic f7,
            int w, int fz, int abort_at, string tag);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        build_path(o, w);
        foreach (path[k]) begin
            if (fz < 0) begin
                zero = 1'($urandom_range(0, 1));
                neg  = 1'($urandom_range(0, 1));
            end else begin
                zero = fz[0];
                neg  = fz[1];
            end
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, k), obs,
                  exp_out(path[k], k == path.size() - 1, o, f3, f7, zero, neg));
            if (k == abort_at) begin
                #1;
                if (sel) rst2 = 1'b1; else rst0 = 1'b1;
                #1;
                check($sformatf("%s_midrst", tag), obs, RST_V);
                @(posedge clk);
                #1;
                if (sel) rst2 = 1'b0; else rst0 = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        if (!is_legal(o)) begin
`ifdef MC_CTRL_TRAP_EN
            reset_cur({tag, "_trst"});
`endif
        end
    endtask

    task automatic run_random(int n, int w);
        logic [6:0] ops [8];
        logic [6:0] o;
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_JALR, OP_BR, OP_LUI};
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                o = 7'($urandom);
                if (is_legal(o)) o = 7'b1111111;
            end else begin
                o = ops[$urandom_range(0, 7)];
            end
            run_instr(o, 3'($urandom), 1'($urandom_range(0, 1)), w, -1, -1,
                      $sformatf("rnd%0d_w%0d", i, w));
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst2 = 1'b1;
        sel = 1'b0;
        op = '0;
        funct3 = '0;
        funct7b5 = 1'b0;
        zero = 1'b0;
        neg = 1'b0;
        @(posedge clk);
        #1;
        reset_cur("rst_w0");
        run_instr(OP_LOAD, 3'b010, 1'b0, 0, -1, -1, "load");
        run_instr(OP_BR, 3'b001, 1'b0, 0, 0, -1, "bne_z0");
        run_instr(OP_BR, 3'b001, 1'b0, 0, 1, -1, "bne_z1");
        run_instr(OP_R, 3'b000, 1'b1, 0, -1, -1, "rsub");
        run_instr(OP_I, 3'b000, 1'b1, 0, -1, -1, "iadd");
        run_instr(OP_JALR, 3'b000, 1'b0, 0, -1, -1, "jalr");
        run_instr(7'b1111111, 3'b000, 1'b0, 0, -1, -1, "illegal");
        run_instr(OP_LUI, 3'b000, 1'b0, 0, -1, -1, "lui");
        run_instr(OP_STORE, 3'b010, 1'b0, 0, -1, 3, "store_abort");
        run_instr(OP_STORE, 3'b010, 1'b0, 0, -1, -1, "store");
        run_random(150, 0);

        rst0 = 1'b1;
        sel = 1'b1;
        reset_cur("rst_w2");
        run_instr(OP_LOAD, 3'b010, 1'b0, 2, -1, -1, "load_w2");
        run_instr(OP_STORE, 3'b010, 1'b0, 2, -1, 5, "store_abort_w2");
        run_instr(OP_JAL, 3'b000, 1'b0, 2, -1, -1, "jal_w2");
        run_random(80, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
